riscv_single_cycle_core: RTL and testbench

- Single-cycle RV32I integer core: one instruction fetched, decoded, executed and retired per clk.
- Drives instruction-memory address (pc) and data-memory address/data/write-enable.
- Consumes fetched instruction (inst) and data-memory read data (MEM_rData).
- Instruction memory and data memory are external. Instruction memory is indexed by pc[9:2]. Data memory is 256 x 32-bit words, combinational read, synchronous write.

---
 rtl/riscv_single_cycle_core.sv | 131 +++++++++++++
 tb/tb_riscv_single_cycle_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_single_cycle_core.sv
// riscv_single_cycle_core: single-cycle RV32I core; define RISCV_HALT_EN to make ECALL/EBREAK freeze the core until reset
module riscv_single_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rset,
  input  logic [31:0] inst,
  input  logic [31:0] MEM_rData,
  output logic [31:0] pc,
  output logic [7:0]  MEM_addr,
  output logic [31:0] MEM_wDATA,
  output logic        dm_we
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  logic [31:0] pc_q, pc_d, pc_4;
  logic [31:0] regs_q [32];
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, op_b, alu, agu, rf_wd;
  logic        take, rf_we, st, freeze;
  assign opc   = inst[6:0];
  assign rd    = inst[11:7];
  assign f3    = inst[14:12];
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign rs1_v = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
  assign op_b  = (opc == OP_R) ? rs2_v : imm_i;
  assign agu   = rs1_v + ((opc == OP_ST) ? imm_s : imm_i);
  assign pc_4  = pc_q + 32'd4;
  assign pc        = pc_q;
  assign MEM_addr  = agu[9:2];
  assign MEM_wDATA = rs2_v;
  assign dm_we     = st & rset;
`ifdef RISCV_HALT_EN
  logic halted_q;
  logic is_sys;
  assign is_sys = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
  assign freeze = halted_q | is_sys;
  // Halt flag latches on ECALL/EBREAK and only reset releases it
  always_ff @(posedge clk or negedge rset)
    if (!rset) halted_q <= 1'b0;
    else       halted_q <= halted_q | is_sys;
`else
  assign freeze = 1'b0;
`endif
  // ALU: shared by register-register and register-immediate forms
  always_comb begin
    alu = 32'd0;
    case (f3)
      3'b000: alu = (opc == OP_R && inst[30]) ? rs1_v - op_b : rs1_v + op_b;
      3'b001: alu = rs1_v << op_b[4:0];
      3'b010: alu = {31'd0, $signed(rs1_v) < $signed(op_b)};
      3'b011: alu = {31'd0, rs1_v < op_b};
      3'b100: alu = rs1_v ^ op_b;
      3'b101: alu = inst[30] ? $unsigned($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
      3'b110: alu = rs1_v | op_b;
      default: alu = rs1_v & op_b;
    endcase
  end
  // Branch condition from funct3; reserved encodings never branch
  always_comb begin
    take = 1'b0;
    case (f3)
      3'b000: take = rs1_v == rs2_v;
      3'b001: take = rs1_v != rs2_v;
      3'b100: take = $signed(rs1_v) < $signed(rs2_v);
      3'b101: take = $signed(rs1_v) >= $signed(rs2_v);
      3'b110: take = rs1_v < rs2_v;
      3'b111: take = rs1_v >= rs2_v;
      default: take = 1'b0;
    endcase
  end
  // Decode: next pc, register write-back and store strobe; unknown opcodes fall through as NOP
  always_comb begin
    pc_d  = pc_4;
    rf_we = 1'b0;
    rf_wd = alu;
    st    = 1'b0;
    case (opc)
      OP_R, OP_I: rf_we = 1'b1;
      OP_LD: begin
        rf_we = (f3 == 3'b010);
        rf_wd = MEM_rData;
      end
      OP_ST: st = (f3 == 3'b010);
      OP_BR: pc_d = take ? pc_q + imm_b : pc_4;
      OP_JAL: begin
        rf_we = 1'b1;
        rf_wd = pc_4;
        pc_d  = pc_q + imm_j;
      end
      OP_JALR: begin
        rf_we = 1'b1;
        rf_wd = pc_4;
        pc_d  = agu & ~32'd1;
      end
      OP_LUI: begin
        rf_we = 1'b1;
        rf_wd = imm_u;
      end
      OP_AUIPC: begin
        rf_we = 1'b1;
        rf_wd = pc_q + imm_u;
      end
      default: ;
    endcase
    if (freeze) begin
      pc_d  = pc_q;
      rf_we = 1'b0;
      st    = 1'b0;
    end
  end
  // Program counter
  always_ff @(posedge clk or negedge rset)
    if (!rset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  // Register file write port; x0 is never written so it stays zero
  always_ff @(posedge clk or negedge rset)
    if (!rset) for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    else if (rf_we && rd != 5'd0) regs_q[rd] <= rf_wd;
endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// tb_riscv_single_cycle_core: directed-vector bench for the single-cycle RV32I core
module tb_riscv_single_cycle_core;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk, rset;
  logic [31:0] inst, MEM_rData, pc, MEM_wDATA;
  logic [7:0]  MEM_addr;
  logic        dm_we;
  logic [31:0] dmem [256];
  logic [31:0] p;
  int          n_chk = 0, n_err = 0;

  riscv_single_cycle_core dut (
    .clk(clk), .rset(rset), .inst(inst), .MEM_rData(MEM_rData),
    .pc(pc), .MEM_addr(MEM_addr), .MEM_wDATA(MEM_wDATA), .dm_we(dm_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MEM_rData = dmem[MEM_addr];
  always @(posedge clk) if (dm_we) dmem[MEM_addr] <= MEM_wDATA;

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exec(input logic [31:0] i);
    inst = i;
    @(posedge clk);
    #1;
  endtask

  // Reads a register through the rs2 -> MEM_wDATA path using an unsupported opcode (no state change)
  task automatic reg_chk(input string tag, input logic [4:0] r, input logic [31:0] exp);
    inst = {7'd0, r, 20'd0};
    #1;
    check(tag, MEM_wDATA, exp);
  endtask

  initial begin
    rset = 1'b0;
    inst = NOP;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_we", {31'd0, dm_we}, 32'd0);
    inst = enc_s(0, 5'd0, 5'd0);
    #1;
    check("rst_sw_we", {31'd0, dm_we}, 32'd0);
    inst = NOP;
    rset = 1'b1;
    #1;
    check("pc0", pc, 32'h0);
    exec(NOP); check("pc4", pc, 32'h4);
    exec(NOP); check("pc8", pc, 32'h8);
    exec(NOP); check("pc12", pc, 32'hC);
    // ALU
    exec(enc_i(5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    exec(enc_i(-3, 5'd0, 3'b000, 5'd2, 7'b0010011));
    exec(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    exec(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));
    exec(enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5));
    exec(enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6));
    exec(enc_i(32'h401, 5'd2, 3'b101, 5'd7, 7'b0010011));
    exec(enc_i(28, 5'd2, 3'b101, 5'd8, 7'b0010011));
    exec(enc_i(3, 5'd1, 3'b001, 5'd9, 7'b0010011));
    exec(enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10));
    reg_chk("add", 5'd3, 32'd2);
    reg_chk("sub", 5'd4, 32'd8);
    reg_chk("slt", 5'd5, 32'd1);
    reg_chk("sltu", 5'd6, 32'd0);
    reg_chk("srai", 5'd7, 32'hFFFF_FFFE);
    reg_chk("srli", 5'd8, 32'h0000_000F);
    reg_chk("slli", 5'd9, 32'd40);
    reg_chk("xor", 5'd10, 32'hFFFF_FFF8);
    // Memory
    exec(enc_i(32'h40, 5'd0, 3'b000, 5'd1, 7'b0010011));
    exec(enc_i(32'h55, 5'd0, 3'b000, 5'd2, 7'b0010011));
    inst = enc_s(8, 5'd2, 5'd1);
    #1;
    check("sw_we", {31'd0, dm_we}, 32'd1);
    check("sw_addr", {24'd0, MEM_addr}, 32'h12);
    check("sw_data", MEM_wDATA, 32'h55);
    @(posedge clk);
    #1;
    inst = enc_i(8, 5'd1, 3'b010, 5'd3, 7'b0000011);
    #1;
    check("lw_we", {31'd0, dm_we}, 32'd0);
    check("lw_addr", {24'd0, MEM_addr}, 32'h12);
    exec(inst);
    reg_chk("lw", 5'd3, 32'h55);
    // Branches
    exec(enc_i(5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    exec(enc_i(-3, 5'd0, 3'b000, 5'd2, 7'b0010011));
    p = pc; exec(enc_b(8, 5'd1, 5'd1, 3'b000)); check("beq", pc, p + 32'd8);
    p = pc; exec(enc_b(8, 5'd1, 5'd1, 3'b001)); check("bne", pc, p + 32'd4);
    p = pc; exec(enc_b(12, 5'd1, 5'd2, 3'b100)); check("blt", pc, p + 32'd12);
    p = pc; exec(enc_b(12, 5'd1, 5'd2, 3'b110)); check("bltu", pc, p + 32'd4);
    p = pc; exec(enc_b(-8, 5'd2, 5'd1, 3'b101)); check("bge", pc, p - 32'd8);
    p = pc; exec(enc_b(-8, 5'd2, 5'd1, 3'b111)); check("bgeu", pc, p + 32'd4);
    // Jumps
    exec(enc_i(32'h20, 5'd0, 3'b000, 5'd0, 7'b1100111));
    check("jalr_abs", pc, 32'h20);
    exec(enc_j(16, 5'd1));
    check("jal_pc", pc, 32'h30);
    reg_chk("jal_link", 5'd1, 32'h24);
    exec(enc_i(7, 5'd1, 3'b000, 5'd0, 7'b1100111));
    check("jalr_pc", pc, 32'h2A);
    // x0, upper immediates, unknown opcode
    exec(enc_i(9, 5'd0, 3'b000, 5'd0, 7'b0010011));
    reg_chk("x0", 5'd0, 32'd0);
    exec({20'h12345, 5'd7, 7'b0110111});
    reg_chk("lui", 5'd7, 32'h1234_5000);
    p = pc; exec({20'h00001, 5'd8, 7'b0010111});
    reg_chk("auipc", 5'd8, p + 32'h1000);
    p = pc; exec({25'h1FF_FFFF & {20'hFFFFF, 5'd7}, 7'b1111111});
    check("unk_pc", pc, p + 32'd4);
    reg_chk("unk_rd", 5'd7, 32'h1234_5000);
    // ECALL
    p = pc;
    exec(32'h0000_0073);
`ifdef RISCV_HALT_EN
    for (int k = 0; k < 5; k++) begin
      exec(enc_i(1, 5'd0, 3'b000, 5'd11, 7'b0010011));
      check("halt_pc", pc, p);
    end
    reg_chk("halt_rf", 5'd11, 32'd0);
`else
    check("ecall_nop", pc, p + 32'd4);
`endif
    // Reset asserted mid-cycle while a store is pending
    inst = enc_s(0, 5'd2, 5'd0);
    #1;
`ifndef RISCV_HALT_EN
    check("mid_sw_we", {31'd0, dm_we}, 32'd1);
`endif
    rset = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, dm_we}, 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    reg_chk("mid_rst_rf", 5'd2, 32'd0);
    @(posedge clk);
    #1;
    rset = 1'b1;
    inst = NOP;
    exec(NOP);
    check("post_rst_pc", pc, 32'h4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
